// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush responder for the 5-stage pipeline. Combines the ID
// load-use hazard, the MEM multi-cycle handshake and the EX taken-branch
// redirect into per-stage hold/flush controls. A small FSM follows
// outstanding memory waits and has a timeout watchdog with a sticky error.
// Optional feature macro: PIPE_STALL_CNT_EN adds the stall_cycles counter.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_req,
  input  logic             branch_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ack,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             hold_id_ex,
  output logic             hold_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_mem_wb,
  output logic             mem_timeout_err
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WC_W-1:0] wait_cnt_reg;
  logic            err_reg;
  logic            mstall;

  // A memory stall is a fresh unacked request in RUN or any unacked cycle of an ongoing wait
  always_comb begin
    mstall = ((state_reg == RUN) && mem_req_MEM && !mem_ack) ||
             ((state_reg == MEM_WAIT) && !mem_ack);
  end

  // Priority resolve: ERR > memory stall > branch flush > load-use bubble
  always_comb begin
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    hold_ex_mem   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    bubble_mem_wb = 1'b0;
    if (rst) begin
      // everything stays quiet while reset is applied
    end else if (state_reg == ERR || mstall) begin
      // freeze the front of the pipe; the stuck access never retires into WB
      hold_pc       = 1'b1;
      hold_if_id    = 1'b1;
      hold_id_ex    = 1'b1;
      hold_ex_mem   = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (branch_taken_EX) begin
      // ID instruction is wrong-path, so a load-use hazard on it is moot
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use_req) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  // Memory-wait FSM with watchdog; the error flag lags ERR entry by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= (state_reg == ERR);
      case (state_reg)
        RUN: begin
          if (mstall) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_reg <= RUN;
          end else if (wait_cnt_reg == WC_W'(MEM_TIMEOUT)) begin
            state_reg <= ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
          end
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          state_reg <= ERR;
        end
      endcase
    end
  end

  assign mem_timeout_err = err_reg;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Count every cycle the PC was held, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (hold_pc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule
